// File: rtl/seg7_scan_driver_if.sv
// Bundle between the calculator datapath (master) and the display scan driver (slave).
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic [3:0]  blank;
  logic        upd_req;
  logic        upd_busy;
  logic        upd_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output value, dp_en, blank, upd_req,
    input  upd_busy, upd_ack, an, seg, dp
  );

  modport slave (
    input  value, dp_en, blank, upd_req,
    output upd_busy, upd_ack, an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment scan driver (active-low anodes/segments).
// Each digit slot opens with an all-off gap to avoid ghosting; new data is
// taken only at frame boundaries so a frame is never torn.
module seg7_scan_driver #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned REFRESH_HZ  = 1_000,
  parameter int unsigned BLANK_CYC   = 100,
  parameter bit          LZ_SUPPRESS = 1'b0
) (
  input logic               clk_in,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_sh_val, r_pd_val;
  logic [3:0]    r_sh_dp, r_sh_bl, r_pd_dp, r_pd_bl;
  logic          r_busy, r_ack;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_wrap, w_frame_end, w_lz, w_dig_off;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_dec;

  assign w_wrap      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_wrap && (r_idx == 2'd3);

  // Prescaler; digit index advances each time the slot counter wraps.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Update handshake: pending is committed to shadow only at a frame boundary.
  // A request on the boundary cycle itself becomes pending for the next frame.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_val <= '0;
      r_sh_dp  <= '0;
      r_sh_bl  <= '0;
      r_pd_val <= '0;
      r_pd_dp  <= '0;
      r_pd_bl  <= '0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_frame_end && r_busy;
      if (w_frame_end && r_busy) begin
        r_sh_val <= r_pd_val;
        r_sh_dp  <= r_pd_dp;
        r_sh_bl  <= r_pd_bl;
      end
      if (bus.upd_req) begin
        r_pd_val <= bus.value;
        r_pd_dp  <= bus.dp_en;
        r_pd_bl  <= bus.blank;
        r_busy   <= 1'b1;
      end else if (w_frame_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign w_nib = r_sh_val[{r_idx, 2'b00} +: 4];

  // Leading-zero test: this digit and every digit to its left are zero.
  always_comb begin
    w_lz = 1'b0;
    unique case (r_idx)
      2'd0: w_lz = 1'b0;
      2'd1: w_lz = (r_sh_val[15:4] == 12'h000);
      2'd2: w_lz = (r_sh_val[15:8] == 8'h00);
      2'd3: w_lz = (r_sh_val[15:12] == 4'h0);
    endcase
  end

  assign w_dig_off = r_sh_bl[r_idx] | (LZ_SUPPRESS & w_lz);

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg_dec = 7'h7F;
    unique case (w_nib)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
    endcase
  end

  // Registered pin drive; blanked slots and digits hold everything off.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if ((r_cnt < CNT_BLANK) || w_dig_off) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg_dec;
      r_dp  <= ~r_sh_dp[r_idx];
    end
  end

  assign bus.upd_busy = r_busy;
  assign bus.upd_ack  = r_ack;
  assign bus.an       = r_an;
  assign bus.seg      = r_seg;
  assign bus.dp       = r_dp;
endmodule
